// File: rtl/fb_scanout_if.sv
// Framebuffer read port and outgoing pixel stream of the scanout engine.
interface fb_scanout_if #(parameter int DATAW = 4);
  logic             frame_start;
  logic [18:0]      fb_addr;
  logic             fb_rd_en;
  logic [DATAW-1:0] fb_rd_data;
  logic [DATAW-1:0] out_pix;
  logic             out_valid;
  logic             out_ready;
  logic             out_sol;
  logic             out_eol;
  logic             out_eof;
  logic             overrun;

  modport master (
    input  frame_start, fb_rd_data, out_ready,
    output fb_addr, fb_rd_en, out_pix, out_valid, out_sol, out_eol, out_eof, overrun
  );
  modport slave (
    output frame_start, fb_rd_data, out_ready,
    input  fb_addr, fb_rd_en, out_pix, out_valid, out_sol, out_eol, out_eof, overrun
  );
endinterface

// File: rtl/fb_scanout.sv
// Framebuffer scanout: prefetches pixels linearly into a small FIFO and
// streams them out with line/frame markers under valid/ready flow control.
module fb_scanout #(
  parameter int H_RES      = 800,
  parameter int V_RES      = 480,
  parameter int DATAW      = 4,
  parameter int FIFO_DEPTH = 8
) (
  input  logic         clk,
  input  logic         rst,
  fb_scanout_if.master bus
);
  localparam int              TOTAL     = H_RES * V_RES;
  localparam int              AW        = $clog2(FIFO_DEPTH);
  localparam int              XW        = (H_RES > 1) ? $clog2(H_RES) : 1;
  localparam int              YW        = (V_RES > 1) ? $clog2(V_RES) : 1;
  localparam logic [18:0]     LAST_ADDR = 19'(TOTAL - 1);
  localparam logic [XW-1:0]   X_LAST    = XW'(H_RES - 1);
  localparam logic [YW-1:0]   Y_LAST    = YW'(V_RES - 1);

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;
  state_t state, state_nxt;

  logic [DATAW-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [AW:0]      count;
  logic             rd_vld;   // a read was issued last cycle; its data is on fb_rd_data
  logic [18:0]      addr;
  logic [XW-1:0]    ox;
  logic [YW-1:0]    oy;
  logic             overrun_q;
  logic             restart, push, pop, rd_en, last_rd, valid, eol, eof;

  assign restart = bus.frame_start;
  assign valid   = (count != '0);
  assign pop     = valid && bus.out_ready;
  assign push    = rd_vld && !restart;
  assign eol     = valid && (ox == X_LAST);
  assign eof     = eol && (oy == Y_LAST);
  assign last_rd = rd_en && (addr == LAST_ADDR);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (restart) state_nxt = FETCH;
    else begin
      case (state)
        FETCH:   if (last_rd) state_nxt = DRAIN;
        DRAIN:   if (pop && eof) state_nxt = IDLE;
        default: ;
      endcase
    end
  end

  // Occupancy plus the single in-flight read bounds prefetch, so a push never overflows.
  always_comb begin
    rd_en = 1'b0;
    if (state == FETCH && !restart)
      rd_en = (int'(count) + int'(rd_vld)) < FIFO_DEPTH;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr      <= '0;
      rd_vld    <= 1'b0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      ox        <= '0;
      oy        <= '0;
      overrun_q <= 1'b0;
    end else if (restart) begin
      if (state != IDLE) overrun_q <= 1'b1;
      addr   <= '0;
      rd_vld <= 1'b0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      ox     <= '0;
      oy     <= '0;
    end else begin
      rd_vld <= rd_en;
      if (rd_en) addr   <= addr + 19'd1;
      if (push)  wr_ptr <= wr_ptr + AW'(1);
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
        if (ox == X_LAST) begin
          ox <= '0;
          oy <= (oy == Y_LAST) ? '0 : oy + YW'(1);
        end else begin
          ox <= ox + XW'(1);
        end
      end
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= bus.fb_rd_data;
  end

  assign bus.fb_addr   = addr;
  assign bus.fb_rd_en  = rd_en;
  assign bus.out_valid = valid;
  assign bus.out_pix   = valid ? mem[rd_ptr] : '0;
  assign bus.out_sol   = valid && (ox == '0);
  assign bus.out_eol   = eol;
  assign bus.out_eof   = eof;
  assign bus.overrun   = overrun_q;
endmodule

// File: tb/tb_fb_scanout.sv
// Randomized bench for fb_scanout: a frame-level model predicts reads and pixels.
module tb_fb_scanout;
  localparam int H = 4, V = 2, D = 4, DEPTH = 4, TOTAL = H * V;

  logic clk = 1'b0;
  logic rst = 1'b1;

  fb_scanout_if #(.DATAW(D)) bus ();
  fb_scanout #(.H_RES(H), .V_RES(V), .DATAW(D), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  always #5 clk = ~clk;

  logic [D-1:0] mem [TOTAL];
  always @(posedge clk) if (bus.fb_rd_en) bus.fb_rd_data <= mem[int'(bus.fb_addr) % TOTAL];

  int n_chk = 0, n_err = 0;
  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Frame model: reads issued minus pixels consumed never reaches DEPTH,
  // data becomes visible two cycles after its read is decided.
  int  exp_idx = 0, rd_idx = 0, rd_hist = 0, n_reads = 0, n_xfer = 0;
  bit  active = 1'b0, exp_ovr = 1'b0;

  always @(negedge clk) begin
    bit was_active, exp_rd;
    int landed, k;
    if (rst) begin
      chk("rst_valid", bus.out_valid, 0);
      chk("rst_rd_en", bus.fb_rd_en, 0);
      chk("rst_overrun", bus.overrun, 0);
      chk("rst_pix", bus.out_pix, 0);
      active = 0; exp_ovr = 0; exp_idx = 0; rd_idx = 0; rd_hist = 0;
    end else begin
      landed  = rd_hist;
      rd_hist = rd_idx;
      exp_rd  = active && rd_idx < TOTAL && (rd_idx - exp_idx) < DEPTH && !bus.frame_start;
      chk("overrun", bus.overrun, exp_ovr);
      chk("rd_en", bus.fb_rd_en, exp_rd);
      if (bus.fb_rd_en) begin
        chk("rd_addr", bus.fb_addr, rd_idx);
        rd_idx++;
        n_reads++;
      end
      chk("out_valid", bus.out_valid, landed > exp_idx);
      if (bus.out_valid) begin
        k = exp_idx % TOTAL;
        chk("out_pix", bus.out_pix, mem[k]);
        chk("out_sol", bus.out_sol, (k % H) == 0);
        chk("out_eol", bus.out_eol, (k % H) == H - 1);
        chk("out_eof", bus.out_eof, k == TOTAL - 1);
      end else begin
        chk("flags_idle", {bus.out_sol, bus.out_eol, bus.out_eof}, 0);
      end
      was_active = active;
      if (bus.out_valid && bus.out_ready) begin
        n_xfer++;
        exp_idx++;
        if (exp_idx == TOTAL) active = 0;
      end
      if (bus.frame_start) begin
        if (was_active) exp_ovr = 1;
        active = 1; exp_idx = 0; rd_idx = 0; rd_hist = 0;
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    bus.frame_start = 1'b1;
    cyc();
    bus.frame_start = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int i = 0;
    while (active && i < budget) begin
      cyc();
      i++;
    end
    chk(tag, active, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    bit found;
    bus.frame_start = 1'b0;
    bus.out_ready   = 1'b0;
    for (int i = 0; i < TOTAL; i++) mem[i] = D'(i);
    repeat (3) cyc();
    rst = 1'b0;
    repeat (2) cyc();
    chk("reset_addr", bus.fb_addr, 0);
    chk("reset_rd_en", bus.fb_rd_en, 0);
    chk("reset_valid", bus.out_valid, 0);

    // full frame, always ready
    bus.out_ready = 1'b1;
    n_xfer = 0;
    pulse_start();
    wait_idle("f_ready_timeout", 100);
    chk("f_ready_xfers", n_xfer, TOTAL);
    repeat (4) cyc();
    chk("f_ready_idle_rd", bus.fb_rd_en, 0);

    // stalled downstream: prefetch stops at FIFO depth
    bus.out_ready = 1'b0;
    n_reads = 0;
    pulse_start();
    repeat (20) cyc();
    chk("stall_reads", n_reads, 4);
    chk("stall_addr", bus.fb_addr, 4);
    chk("stall_valid", bus.out_valid, 1);
    chk("stall_pix", bus.out_pix, 0);
    bus.out_ready = 1'b1;
    wait_idle("stall_timeout", 100);

    // ready toggling every cycle
    n_xfer = 0;
    pulse_start();
    for (int i = 0; i < 200 && active; i++) begin
      bus.out_ready = ~bus.out_ready;
      cyc();
    end
    chk("toggle_done", active, 0);
    chk("toggle_xfers", n_xfer, TOTAL);

    // restart while pixel 5 is presented
    bus.out_ready = 1'b1;
    pulse_start();
    found = 1'b0;
    for (int i = 0; i < 50 && !found; i++) begin
      if (bus.out_valid && exp_idx == 5) found = 1'b1;
      else cyc();
    end
    chk("restart_found", found, 1);
    pulse_start();
    chk("restart_overrun", bus.overrun, 1);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (bus.out_valid) found = 1'b1;
      else cyc();
    end
    chk("restart_first_pix", bus.out_pix, 0);
    chk("restart_first_sol", bus.out_sol, 1);
    wait_idle("restart_timeout", 100);

    // reset while FIFO holds data
    bus.out_ready = 1'b0;
    pulse_start();
    repeat (6) cyc();
    chk("rstmid_valid_before", bus.out_valid, 1);
    rst = 1'b1;
    cyc();
    chk("rstmid_valid", bus.out_valid, 0);
    chk("rstmid_overrun", bus.overrun, 0);
    rst = 1'b0;
    n_reads = 0;
    repeat (10) cyc();
    chk("rstmid_no_reads", n_reads, 0);

    // randomized frames with random backpressure, restarts and resets
    for (int it = 0; it < 40; it++) begin
      int ncyc;
      for (int i = 0; i < TOTAL; i++) mem[i] = D'($urandom);
      bus.out_ready = ($urandom_range(0, 1) == 1);
      pulse_start();
      ncyc = $urandom_range(5, 60);
      for (int c = 0; c < ncyc; c++) begin
        bus.out_ready = ($urandom_range(0, 99) < 60);
        if ($urandom_range(0, 99) == 0) begin
          rst = 1'b1;
          cyc();
          rst = 1'b0;
        end else begin
          if ($urandom_range(0, 39) == 0) bus.frame_start = 1'b1;
          cyc();
          bus.frame_start = 1'b0;
        end
      end
      bus.out_ready = 1'b1;
      wait_idle("rand_timeout", 200);
      repeat (2) cyc();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/fb_scanout.md
FB_SCANOUT -- requirements
Module: fb_scanout

Interface
REQ-001 Parameter H_RES, default 800: displayed pixels per line.
REQ-002 Parameter V_RES, default 480: displayed lines per frame.
REQ-003 Parameter DATAW, default 4: pixel colour-index width.
REQ-004 Parameter FIFO_DEPTH, default 8: prefetch FIFO entries, power of two, >= 4.
REQ-005 clk  in  1  sole clock; all state changes on rising edge.
REQ-006 rst  in  1  asynchronous, active-high reset.
REQ-007 frame_start  in  1  one-cycle pulse; begin scanout of a new frame.
REQ-008 fb_addr  out  19  framebuffer read address, linear index y*H_RES+x.
REQ-009 fb_rd_en  out  1  framebuffer read strobe; data returns exactly one cycle later.
REQ-010 fb_rd_data  in  DATAW  framebuffer read data, valid the cycle after fb_rd_en.
REQ-011 out_pix  out  DATAW  streamed pixel colour index.
REQ-012 out_valid  out  1  out_pix and flags valid.
REQ-013 out_ready  in  1  downstream accepts the pixel.
REQ-014 out_sol / out_eol  out  1 each  pixel is first / last of its line.
REQ-015 out_eof  out  1  pixel is last pixel of the frame.
REQ-016 overrun  out  1  sticky: frame_start arrived before previous frame completed.

Function
REQ-017 States: IDLE, FETCH, DRAIN; reset state IDLE.
REQ-018 IDLE -> FETCH on frame_start; read address, output x/y counters, FIFO and in-flight count all cleared that cycle.
REQ-019 FETCH: assert fb_rd_en when FIFO occupancy + in-flight reads < FIFO_DEPTH; fb_addr increments by 1 after each issued read.
REQ-020 FETCH -> DRAIN after the read at address H_RES*V_RES-1 is issued; no reads issued in DRAIN or IDLE.
REQ-021 Returned data is pushed into the FIFO the cycle after its fb_rd_en; the FIFO never overflows.
REQ-022 out_valid = FIFO non-empty; out_pix = FIFO head; transfer occurs when out_valid && out_ready, popping one entry.
REQ-023 out_pix/flags remain stable while out_valid && !out_ready.
REQ-024 Output counters ox (0..H_RES-1), oy (0..V_RES-1) advance on each transfer; ox wraps to 0 and oy increments at ox==H_RES-1.
REQ-025 out_sol = (ox==0); out_eol = (ox==H_RES-1); out_eof = out_eol && (oy==V_RES-1); all gated by out_valid.
REQ-026 DRAIN -> IDLE on the transfer with out_eof; simultaneous push and pop leaves occupancy unchanged.
REQ-027 frame_start in FETCH or DRAIN: set overrun, flush FIFO, discard any read data returning next cycle, restart per REQ-018, state FETCH.
REQ-028 frame_start in IDLE never sets overrun.
REQ-029 Address arithmetic 19-bit unsigned; H_RES*V_RES <= 524288 required.

Reset
REQ-030 On rst: state IDLE; fb_addr=0, fb_rd_en=0, out_valid=0, out_pix=0, out_sol=0, out_eol=0, out_eof=0, overrun=0; FIFO empty; in-flight count 0.
REQ-031 rst asserted mid-frame aborts immediately; read data returning after reset release is discarded.
REQ-032 After rst release no read is issued until frame_start.

Verification (H_RES=4, V_RES=2, FIFO_DEPTH=4, memory[i]=i)
REQ-033 Reset then frame_start, out_ready=1 -> out_pix 0..7 in order, sol on 0,4, eol on 3,7, eof on 7 only, then IDLE, fb_rd_en=0.
REQ-034 out_ready=0 after frame_start -> exactly 4 reads issued (addr 0..3), fb_rd_en then 0, out_pix held at 0.
REQ-035 out_ready toggling 1/0 each cycle -> sequence 0..7 intact, no duplicates, no drops.
REQ-036 frame_start during pixel 5 -> overrun=1, next transferred pixel is 0 with out_sol=1.
REQ-037 rst asserted while FIFO holds data -> out_valid=0 next cycle, overrun=0, no reads until frame_start.
REQ-038 Default parameters, full frame -> 384000 transfers, last fb_addr=383999, one out_eof.
